ps2_keyboard: RTL and testbench



---
 rtl/ps2_keyboard.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 set-2 keyboard receiver with Apple-1 KBD/KBDCR registers; optional PS2_KBD_CTRL_EN adds ctrl-letter codes
`timescale 1ns/1ps

module ps2_keyboard #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_din,
    input  logic       enable,
    input  logic       address,
    output logic [7:0] dout
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } frame_state_t;

    logic          ps2_clk_s1, ps2_clk_s2;
    logic          ps2_din_s1, ps2_din_s2;
    logic [FW-1:0] flt_cnt;
    logic          clk_filt;
    logic          flt_done;
    logic          fall_edge;

    frame_state_t  state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift_reg, shift_n;
    logic          parity_bit, parity_n;
    logic          byte_valid, byte_valid_n;
    logic [7:0]    rx_byte, rx_byte_n;
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;

    logic          ext_flag, rel_flag, shift_flag;
    logic [7:0]    kbd_data;
    logic          kbd_strobe;
    logic          key_hit;
    logic [6:0]    key_ascii;
    logic          key_make;
    logic          is_shift_code;

`ifdef PS2_KBD_CTRL_EN
    logic          ctrl_flag;
`endif

    // Two-flop synchronisers; lines idle high so reset to 1
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2_clk_s1 <= 1'b1;
            ps2_clk_s2 <= 1'b1;
            ps2_din_s1 <= 1'b1;
            ps2_din_s2 <= 1'b1;
        end else begin
            ps2_clk_s1 <= ps2_clk;
            ps2_clk_s2 <= ps2_clk_s1;
            ps2_din_s1 <= ps2_din;
            ps2_din_s2 <= ps2_din_s1;
        end
    end

    assign flt_done  = (flt_cnt == FW'(FILTER_LEN - 1));
    // An edge is accepted in the cycle the filter commits a 1->0 change
    assign fall_edge = clk_filt & ~ps2_clk_s2 & flt_done;

    // Glitch filter: follow the synchronised clock only after FILTER_LEN cycles of disagreement
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
        end else if (ps2_clk_s2 == clk_filt) begin
            flt_cnt  <= '0;
        end else if (flt_done) begin
            clk_filt <= ps2_clk_s2;
            flt_cnt  <= '0;
        end else begin
            flt_cnt  <= flt_cnt + 1'b1;
        end
    end

    assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Inter-edge watchdog; only runs while a frame is in progress
    always_ff @(posedge clk) begin
        if (reset || fall_edge || state == S_IDLE) begin
            to_cnt <= '0;
        end else if (!timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
            byte_valid <= 1'b0;
            rx_byte    <= 8'h00;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift_reg  <= shift_n;
            parity_bit <= parity_n;
            byte_valid <= byte_valid_n;
            rx_byte    <= rx_byte_n;
        end
    end

    // Frame FSM next state: start, 8 data bits LSB first, odd parity, stop
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift_reg;
        parity_n     = parity_bit;
        byte_valid_n = 1'b0;
        rx_byte_n    = rx_byte;
        if (state != S_IDLE && timeout_hit) begin
            state_n = S_IDLE;
        end else if (fall_edge) begin
            case (state)
                S_IDLE: begin
                    if (!ps2_din_s2) begin
                        state_n   = S_DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_n   = {ps2_din_s2, shift_reg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_n = ps2_din_s2;
                    state_n  = S_STOP;
                end
                S_STOP: begin
                    if (ps2_din_s2 && (^{shift_reg, parity_bit})) begin
                        byte_valid_n = 1'b1;
                        rx_byte_n    = shift_reg;
                    end
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Set-2 scancode to 7-bit ASCII, US layout, letters always uppercase
    always_comb begin
        key_hit   = 1'b1;
        key_ascii = 7'h00;
        case (rx_byte)
            8'h1C: key_ascii = 7'h41;
            8'h32: key_ascii = 7'h42;
            8'h21: key_ascii = 7'h43;
            8'h23: key_ascii = 7'h44;
            8'h24: key_ascii = 7'h45;
            8'h2B: key_ascii = 7'h46;
            8'h34: key_ascii = 7'h47;
            8'h33: key_ascii = 7'h48;
            8'h43: key_ascii = 7'h49;
            8'h3B: key_ascii = 7'h4A;
            8'h42: key_ascii = 7'h4B;
            8'h4B: key_ascii = 7'h4C;
            8'h3A: key_ascii = 7'h4D;
            8'h31: key_ascii = 7'h4E;
            8'h44: key_ascii = 7'h4F;
            8'h4D: key_ascii = 7'h50;
            8'h15: key_ascii = 7'h51;
            8'h2D: key_ascii = 7'h52;
            8'h1B: key_ascii = 7'h53;
            8'h2C: key_ascii = 7'h54;
            8'h3C: key_ascii = 7'h55;
            8'h2A: key_ascii = 7'h56;
            8'h1D: key_ascii = 7'h57;
            8'h22: key_ascii = 7'h58;
            8'h35: key_ascii = 7'h59;
            8'h1A: key_ascii = 7'h5A;
            8'h45: key_ascii = shift_flag ? 7'h29 : 7'h30;
            8'h16: key_ascii = shift_flag ? 7'h21 : 7'h31;
            8'h1E: key_ascii = shift_flag ? 7'h40 : 7'h32;
            8'h26: key_ascii = shift_flag ? 7'h23 : 7'h33;
            8'h25: key_ascii = shift_flag ? 7'h24 : 7'h34;
            8'h2E: key_ascii = shift_flag ? 7'h25 : 7'h35;
            8'h36: key_ascii = shift_flag ? 7'h5E : 7'h36;
            8'h3D: key_ascii = shift_flag ? 7'h26 : 7'h37;
            8'h3E: key_ascii = shift_flag ? 7'h2A : 7'h38;
            8'h46: key_ascii = shift_flag ? 7'h28 : 7'h39;
            8'h41: key_ascii = shift_flag ? 7'h3C : 7'h2C;
            8'h49: key_ascii = shift_flag ? 7'h3E : 7'h2E;
            8'h4A: key_ascii = shift_flag ? 7'h3F : 7'h2F;
            8'h4C: key_ascii = shift_flag ? 7'h3A : 7'h3B;
            8'h52: key_ascii = shift_flag ? 7'h22 : 7'h27;
            8'h4E: key_ascii = shift_flag ? 7'h5F : 7'h2D;
            8'h55: key_ascii = shift_flag ? 7'h2B : 7'h3D;
            8'h29: key_ascii = 7'h20;
            8'h5A: key_ascii = 7'h0D;
            8'h66: key_ascii = 7'h5F;
            8'h76: key_ascii = 7'h1B;
            default: key_hit = 1'b0;
        endcase
`ifdef PS2_KBD_CTRL_EN
        // Letters are the only table entries in 0x41..0x5A, so the range identifies them
        if (ctrl_flag && key_ascii >= 7'h41 && key_ascii <= 7'h5A) begin
            key_ascii = key_ascii & 7'h1F;
        end
`endif
    end

    assign is_shift_code = (rx_byte == 8'h12) || (rx_byte == 8'h59);
    // Extended codes are dropped except keypad Enter (E0 5A); breaks never produce a key
    assign key_make = byte_valid && key_hit && !rel_flag && (!ext_flag || rx_byte == 8'h5A);

    // Prefix/modifier tracking and the KBD/KBDCR registers; a new key beats a same-cycle read-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_flag   <= 1'b0;
            rel_flag   <= 1'b0;
            shift_flag <= 1'b0;
`ifdef PS2_KBD_CTRL_EN
            ctrl_flag  <= 1'b0;
`endif
            kbd_data   <= 8'h00;
            kbd_strobe <= 1'b0;
        end else begin
            if (enable && !address) begin
                kbd_strobe <= 1'b0;
            end
            if (byte_valid) begin
                if (rx_byte == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    rel_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    rel_flag <= 1'b0;
                    if (is_shift_code && !ext_flag) begin
                        shift_flag <= !rel_flag;
                    end
`ifdef PS2_KBD_CTRL_EN
                    if (rx_byte == 8'h14) begin
                        ctrl_flag <= !rel_flag;
                    end
`endif
                end
            end
            if (key_make) begin
                kbd_data   <= {1'b1, key_ascii};
                kbd_strobe <= 1'b1;
            end
        end
    end

    assign dout = address ? {kbd_strobe, 7'b0} : kbd_data;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - self-checking bench for ps2_keyboard with a scancode reference model
`timescale 1ns/1ps

module tb_ps2_keyboard;

    localparam int HALF    = 12;
    localparam int TIMEOUT = 50000;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_din;
    logic       enable;
    logic       address;
    logic [7:0] dout;

    int n_cmp = 0;
    int n_err = 0;
    int last_lat = -1;
    int key_latency = 0;

    // reference model state
    bit         m_shift, m_ctrl, m_rel, m_ext, m_strobe;
    logic [7:0] m_data;

    logic [7:0] letter_sc [0:25] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                     8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                     8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_sc [0:9]   = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] punct_sc [0:6]   = '{8'h41, 8'h49, 8'h4A, 8'h4C, 8'h52, 8'h4E, 8'h55};
    string digit_sym = ")!@#$%^&*(";
    string punct_lo  = ",./;'-=";
    string punct_hi  = "<>?:\"_+";
    logic [7:0] pool [0:27] = '{8'h1C, 8'h32, 8'h21, 8'h3A, 8'h1A, 8'h16, 8'h45, 8'h46, 8'h36, 8'h29,
                                8'h5A, 8'h66, 8'h76, 8'h41, 8'h49, 8'h4A, 8'h4C, 8'h52, 8'h4E, 8'h55,
                                8'hE0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h05, 8'h0D, 8'hAA};

    always #20 clk = ~clk;

    ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk     (clk),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_din (ps2_din),
        .enable  (enable),
        .address (address),
        .dout    (dout)
    );

    function automatic int model_map(input logic [7:0] code, input bit sh, input bit ct);
        for (int i = 0; i < 26; i++)
            if (letter_sc[i] == code) return ct ? (32'h81 + i) : (32'hC1 + i);
        for (int i = 0; i < 10; i++)
            if (digit_sc[i] == code) return 32'h80 | (sh ? int'(digit_sym[i]) : (32'h30 + i));
        for (int i = 0; i < 7; i++)
            if (punct_sc[i] == code) return 32'h80 | (sh ? int'(punct_hi[i]) : int'(punct_lo[i]));
        if (code == 8'h29) return 32'hA0;
        if (code == 8'h5A) return 32'h8D;
        if (code == 8'h66) return 32'hDF;
        if (code == 8'h76) return 32'h9B;
        return -1;
    endfunction

    task automatic model_reset();
        m_shift = 0; m_ctrl = 0; m_rel = 0; m_ext = 0; m_strobe = 0; m_data = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] code);
        int a;
        if (code == 8'hE0) m_ext = 1;
        else if (code == 8'hF0) m_rel = 1;
        else begin
            if (!m_ext && (code == 8'h12 || code == 8'h59)) m_shift = !m_rel;
`ifdef PS2_KBD_CTRL_EN
            else if (code == 8'h14) m_ctrl = !m_rel;
`endif
            else if (!m_rel && (!m_ext || code == 8'h5A)) begin
                a = model_map(code, m_shift, m_ctrl);
                if (a >= 0) begin
                    m_data = a[7:0];
                    m_strobe = 1;
                end
            end
            m_ext = 0;
            m_rel = 0;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    // drives nbits of a frame; on the stop bit, watches KBDCR for the strobe and can fire a read
    task automatic send_raw(input logic [10:0] bits, input int nbits, input int read_at);
        last_lat = -1;
        for (int b = 0; b < nbits; b++) begin
            @(negedge clk);
            ps2_din = bits[b];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (b == 10) begin
                for (int k = 1; k <= 2 * HALF; k++) begin
                    if (k == read_at) begin
                        enable = 1'b1;
                        address = 1'b0;
                    end
                    @(posedge clk);
                    @(negedge clk);
                    enable = 1'b0;
                    address = 1'b1;
                    #1;
                    if (last_lat < 0 && dout == 8'h80) last_lat = k;
                end
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_din = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_raw(mk_frame(d, 0, 0), 11, -1);
        model_byte(d);
    endtask

    task automatic peek(input logic a, output logic [7:0] v);
        @(negedge clk);
        address = a;
        #1 v = dout;
    endtask

    task automatic bus_clear();
        @(negedge clk);
        address = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        m_strobe = 0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        peek(1'b0, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL reset_kbd: got %02h expected 00", v); end
        peek(1'b1, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL reset_kbdcr: got %02h expected 00", v); end
    endtask

    task automatic test_basic_key();
        logic [7:0] v;
        send_byte(8'h1C);
        key_latency = last_lat;
        n_cmp++; if (last_lat < 0) begin n_err++; $display("FAIL basic_strobe_seen: got none expected strobe within %0d clk", 2 * HALF); end
        n_cmp++; if (last_lat < 9 || last_lat > 13) begin n_err++; $display("FAIL basic_latency: got %0d expected 9..13", last_lat); end
        peek(1'b1, v);
        n_cmp++; if (v !== 8'h80) begin n_err++; $display("FAIL basic_kbdcr: got %02h expected 80", v); end
        peek(1'b0, v);
        n_cmp++; if (v !== 8'hC1) begin n_err++; $display("FAIL basic_kbd: got %02h expected C1", v); end
        bus_clear();
        address = 1'b1;
        #1 v = dout;
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL basic_clear: got %02h expected 00", v); end
        peek(1'b0, v);
        n_cmp++; if (v !== 8'hC1) begin n_err++; $display("FAIL basic_data_kept: got %02h expected C1", v); end
    endtask

    task automatic test_break_ignored();
        logic [7:0] v;
        send_byte(8'hF0);
        send_byte(8'h1C);
        peek(1'b1, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL break_strobe: got %02h expected 00", v); end
        peek(1'b0, v);
        n_cmp++; if (v !== 8'hC1) begin n_err++; $display("FAIL break_data: got %02h expected C1", v); end
        send_byte(8'h5A);
        peek(1'b1, v);
        n_cmp++; if (v !== 8'h80) begin n_err++; $display("FAIL enter_strobe: got %02h expected 80", v); end
        peek(1'b0, v);
        n_cmp++; if (v !== 8'h8D) begin n_err++; $display("FAIL enter_data: got %02h expected 8D", v); end
        bus_clear();
    endtask

    task automatic test_shift();
        logic [7:0] v;
        send_byte(8'h12);
        send_byte(8'h16);
        peek(1'b0, v);
        n_cmp++; if (v !== 8'hA1) begin n_err++; $display("FAIL shift_1: got %02h expected A1", v); end
        bus_clear();
        send_byte(8'hF0);
        send_byte(8'h12);
        peek(1'b1, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL shift_break_strobe: got %02h expected 00", v); end
        send_byte(8'h16);
        peek(1'b0, v);
        n_cmp++; if (v !== 8'hB1) begin n_err++; $display("FAIL unshift_1: got %02h expected B1", v); end
        peek(1'b1, v);
        n_cmp++; if (v !== 8'h80) begin n_err++; $display("FAIL unshift_strobe: got %02h expected 80", v); end
        bus_clear();
    endtask

    task automatic test_bad_frames();
        logic [7:0] v;
        send_raw(mk_frame(8'h1C, 1, 0), 11, -1);
        peek(1'b1, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL bad_parity_strobe: got %02h expected 00", v); end
        send_raw(mk_frame(8'h1C, 0, 1), 11, -1);
        peek(1'b1, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL bad_stop_strobe: got %02h expected 00", v); end
        peek(1'b0, v);
        n_cmp++; if (v !== 8'hB1) begin n_err++; $display("FAIL bad_frame_data: got %02h expected B1", v); end
        @(negedge clk);
        ps2_din = 1'b0;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        ps2_din = 1'b1;
        send_byte(8'h1C);
        peek(1'b1, v);
        n_cmp++; if (v !== 8'h80) begin n_err++; $display("FAIL glitch_strobe: got %02h expected 80", v); end
        peek(1'b0, v);
        n_cmp++; if (v !== 8'hC1) begin n_err++; $display("FAIL glitch_data: got %02h expected C1", v); end
        bus_clear();
    endtask

    task automatic test_timeout();
        logic [7:0] v;
        send_raw(mk_frame(8'h29, 0, 0), 4, -1);
        repeat (TIMEOUT + 10) @(negedge clk);
        send_byte(8'h29);
        peek(1'b1, v);
        n_cmp++; if (v !== 8'h80) begin n_err++; $display("FAIL timeout_strobe: got %02h expected 80", v); end
        peek(1'b0, v);
        n_cmp++; if (v !== 8'hA0) begin n_err++; $display("FAIL timeout_data: got %02h expected A0", v); end
    endtask

    task automatic test_collision();
        logic [7:0] v;
        send_byte(8'h45);
        send_raw(mk_frame(8'h2E, 0, 0), 11, key_latency);
        model_byte(8'h2E);
        peek(1'b1, v);
        n_cmp++; if (v !== 8'h80) begin n_err++; $display("FAIL collide_strobe: got %02h expected 80", v); end
        peek(1'b0, v);
        n_cmp++; if (v !== 8'hB5) begin n_err++; $display("FAIL collide_data: got %02h expected B5", v); end
        bus_clear();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] v;
        send_byte(8'h12);
        send_raw(mk_frame(8'h16, 0, 0), 5, -1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        peek(1'b0, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL midreset_kbd: got %02h expected 00", v); end
        peek(1'b1, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL midreset_kbdcr: got %02h expected 00", v); end
        send_byte(8'h16);
        peek(1'b0, v);
        n_cmp++; if (v !== 8'hB1) begin n_err++; $display("FAIL midreset_shift_cleared: got %02h expected B1", v); end
        bus_clear();
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic [7:0] code;
        for (int i = 0; i < 30; i++) begin
            code = pool[$urandom_range(27, 0)];
            send_byte(code);
            peek(1'b0, v);
            n_cmp++; if (v !== m_data) begin n_err++; $display("FAIL rnd_kbd[%0d] code %02h: got %02h expected %02h", i, code, v, m_data); end
            peek(1'b1, v);
            n_cmp++; if (v !== {m_strobe, 7'b0}) begin n_err++; $display("FAIL rnd_kbdcr[%0d] code %02h: got %02h expected %02h", i, code, v, {m_strobe, 7'b0}); end
            if ($urandom_range(2, 0) == 0) bus_clear();
        end
    endtask

    initial begin
        #(40 * 95000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_din = 1'b1;
        enable = 1'b0;
        address = 1'b0;
        model_reset();
        test_reset();
        test_basic_key();
        test_break_ignored();
        test_shift();
        test_bad_frames();
        test_timeout();
        test_collision();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
